uart_tx_periph: RTL

//  Memory-mapped, FIFO-buffered 8N1 UART transmitter. It sits on the bridge side of the CPU data bus.
//  The bridge decodes Bus_addr, then drives cs/we/addr/wdata. This block returns rdata combinationally in
//  the same cycle, as the single-cycle core requires. Stores are queued so the core never stalls on serial output.

---
 rtl/uart_tx_periph.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_periph.sv
// uart_tx_periph -- memory-mapped, FIFO-buffered 8N1 UART transmitter.
//
// Stores to TXDATA are queued in a circular FIFO, so the CPU never waits on the
// serial line. A small FSM drains the FIFO one frame at a time. Register reads
// are purely combinational, which lets a single-cycle core use them directly.
//
// Register map (word offset on addr):
//   0 TXDATA  W: push wdata[7:0]            R: 0
//   1 STATUS  R: [0]full [1]empty [2]busy [3]overflow [16:8]count
//             W: wdata[3]=1 clears overflow
//   2 BAUDDIV R/W [15:0] clock cycles per bit; writing 0 stores 1
//   3 CTRL    R/W [0] IE (only with UART_TX_IRQ_EN, otherwise reads 0)
//
// Ports:
//   cpu_clk   in   system clock, rising-edge
//   cpu_rst   in   asynchronous active-low reset
//   cs        in   chip select from the bus bridge
//   we        in   write strobe (qualified by cs)
//   addr      in   [1:0] word offset
//   wdata     in   [31:0] write data
//   rdata     out  [31:0] read data, 0 when cs=0
//   uart_txd  out  serial output, idle high
//   irq       out  TX-done level interrupt (only with UART_TX_IRQ_EN)
//
// Configuration macro: UART_TX_IRQ_EN adds the CTRL.IE bit and the irq port.

module uart_tx_periph #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_txd
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = FIFO_DEPTH[CW-1:0];

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [8:0]    count_ext;
  logic          overflow;
  logic [15:0]   baud_div;

  logic [1:0]    state;
  logic [7:0]    shift;
  logic [2:0]    bitcnt;
  logic [15:0]   fdiv;
  logic [15:0]   baud;

  logic fifo_full;
  logic fifo_empty;
  logic busy;
  logic wr_txdata;
  logic wr_status;
  logic wr_baud;
  logic push;
  logic pop;
  logic bit_end;
  logic unused_wdata;

  assign fifo_full  = (count == COUNT_FULL);
  assign fifo_empty = (count == '0);
  assign busy       = (state != ST_IDLE);
  assign count_ext  = 9'(count);

  assign wr_txdata = cs && we && (addr == 2'd0);
  assign wr_status = cs && we && (addr == 2'd1);
  assign wr_baud   = cs && we && (addr == 2'd2);

  // A push into a full FIFO is dropped. The pop decision looks at the
  // registered count, so a byte written while empty is only taken next edge.
  assign push    = wr_txdata && !fifo_full;
  assign pop     = (state == ST_IDLE) && !fifo_empty;
  assign bit_end = (baud == fdiv - 16'd1);

  assign unused_wdata = ^wdata[31:16];

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage has no reset: after reset the pointers say empty, so old contents are unreachable.
  always_ff @(posedge cpu_clk) begin
    if (push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      overflow <= 1'b0;
      baud_div <= DIV_RESET;
    end else begin
      if (wr_txdata && fifo_full)     overflow <= 1'b1;
      else if (wr_status && wdata[3]) overflow <= 1'b0;
      if (wr_baud) baud_div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
    end
  end

  // Frame FSM. The divider is latched at pop time so a BAUDDIV write
  // during a frame only takes effect on the next one.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state  <= ST_IDLE;
      shift  <= 8'd0;
      bitcnt <= 3'd0;
      fdiv   <= 16'd1;
      baud   <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift  <= fifo_mem[rd_ptr];
            fdiv   <= baud_div;
            bitcnt <= 3'd0;
            baud   <= 16'd0;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud  <= 16'd0;
            state <= ST_DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud   <= 16'd0;
            shift  <= {1'b0, shift[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= ST_STOP;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud  <= 16'd0;
            state <= ST_IDLE;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // txd is a flop (one cycle behind the FSM) with an async set, so it is
  // glitch-free and goes high immediately when reset hits mid-frame.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      uart_txd <= 1'b1;
    end else begin
      case (state)
        ST_START: uart_txd <= 1'b0;
        ST_DATA:  uart_txd <= shift[0];
        default:  uart_txd <= 1'b1;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  logic ie;
  logic wr_ctrl;

  assign wr_ctrl = cs && we && (addr == 2'd3);

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_ctrl) ie <= wdata[0];
      irq <= ie && fifo_empty && (state == ST_IDLE);
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (cs) begin
      case (addr)
        2'd1:    rdata = {15'd0, count_ext, 4'd0, overflow, busy, fifo_empty, fifo_full};
        2'd2:    rdata = {16'd0, baud_div};
`ifdef UART_TX_IRQ_EN
        2'd3:    rdata = {31'd0, ie};
`endif
        default: rdata = '0;
      endcase
    end
  end

endmodule
